// File: rtl/axis_fifo_pkg.sv
// Shared width helpers and the stored-beat layout for the AXI4-Stream FIFO.
package axis_fifo_pkg;

    localparam int AXIS_WIDTH = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return r;
    endfunction

    // A stored beat is data, one keep bit per byte, and last.
    function automatic int beat_width(input int width);
        return width + width / 8 + 1;
    endfunction

    localparam int AXIS_BEAT_W = beat_width(AXIS_WIDTH);

    typedef struct packed {
        logic [AXIS_WIDTH-1:0]   data;
        logic [AXIS_WIDTH/8-1:0] keep;
        logic                    last;
    } axis_beat_t;

endpackage

// File: rtl/axis_fifo_ptr.sv
// Circular FIFO pointer: index bits plus one wrap bit, advanced by an enable.
module axis_fifo_ptr
    import axis_fifo_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int PW    = clog2(DEPTH) + 1
) (
    input  logic          aclk,
    input  logic          aresetn,
    input  logic          inc,
    output logic [PW-1:0] ptr
);

    logic [PW-1:0] ptr_d, ptr_q;

    // NOTE: the default assignment comes first so no path leaves ptr_d unassigned (no latch).
    always_comb begin
        ptr_d = ptr_q;
        if (inc) ptr_d = ptr_q + PW'(1);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) ptr_q <= '0;
        else          ptr_q <= ptr_d;
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/axis_fifo_buf.sv
// Fully decoupled AXI4-Stream FIFO with first-word-fall-through output and
// optional store-and-forward packet mode.
module axis_fifo_buf
    import axis_fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter bit PACKET_MODE = 1'b0
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    output logic                  s_ready,
    input  logic                  s_valid,
    input  logic                  s_last,
    input  logic [WIDTH-1:0]      s_data,
    input  logic [WIDTH/8-1:0]    s_keep,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic                  m_last,
    output logic [WIDTH-1:0]      m_data,
    output logic [WIDTH/8-1:0]    m_keep,
    output logic [clog2(DEPTH):0] level,
    output logic                  full,
    output logic                  empty
);

    localparam int AW = clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int KW = WIDTH / 8;
    localparam int BW = beat_width(WIDTH);

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [KW-1:0]    keep;
        logic             last;
    } beat_t;

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          push, pop;
    logic          ptr_empty, ptr_full;
    logic          ready_en_d, ready_en_q;
    logic [PW-1:0] level_d, level_q;
    logic [PW-1:0] pkt_cnt_d, pkt_cnt_q;
    logic [BW-1:0] mem_q [DEPTH];
    beat_t         head;

    axis_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (push),
        .ptr     (wr_ptr)
    );

    axis_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .aclk    (aclk),
        .aresetn (aresetn),
        .inc     (pop),
        .ptr     (rd_ptr)
    );

    // Equal index bits mean empty or full; the wrap bit tells which.
    assign ptr_empty = (wr_ptr == rd_ptr);
    assign ptr_full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    assign s_ready = ready_en_q & ~ptr_full;
    assign push    = s_valid & s_ready;
    assign pop     = m_valid & m_ready;

    // Packet mode holds the head back until a whole packet is stored, unless
    // the buffer is full, which lets oversize packets drain as cut-through.
    always_comb begin
        m_valid = ~ptr_empty;
        if (PACKET_MODE) m_valid = ~ptr_empty & ((pkt_cnt_q != '0) | ptr_full);
    end

    assign head = mem_q[rd_ptr[AW-1:0]];

    always_comb begin
        m_data = '0;
        m_keep = '0;
        m_last = 1'b0;
        if (m_valid) begin
            m_data = head.data;
            m_keep = head.keep;
            m_last = head.last;
        end
    end

    always_comb begin
        ready_en_d = 1'b1;
        level_d    = level_q;
        pkt_cnt_d  = pkt_cnt_q;
        if (push && !pop)      level_d = level_q + PW'(1);
        else if (pop && !push) level_d = level_q - PW'(1);
        if ((push && s_last) && !(pop && m_last))      pkt_cnt_d = pkt_cnt_q + PW'(1);
        else if ((pop && m_last) && !(push && s_last)) pkt_cnt_d = pkt_cnt_q - PW'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            ready_en_q <= 1'b0;
            level_q    <= '0;
            pkt_cnt_q  <= '0;
        end else begin
            ready_en_q <= ready_en_d;
            level_q    <= level_d;
            pkt_cnt_q  <= pkt_cnt_d;
        end
    end

    // NOTE: storage is deliberately not reset; cleared pointers make stale entries unreachable.
    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr[AW-1:0]] <= {s_data, s_keep, s_last};
    end

    assign level = level_q;
    assign full  = ptr_full;
    assign empty = ptr_empty;

endmodule

// File: tb/tb_axis_fifo_buf.sv
// Self-checking bench: a cut-through DEPTH=4 instance and a packet-mode
// DEPTH=8 instance, both checked every cycle against a queue-based model.
`timescale 1ns/1ps
module tb_axis_fifo_buf;
    import axis_fifo_pkg::*;

    logic aclk = 1'b0;
    logic aresetn = 1'b0;
    always #5 aclk = ~aclk;

    logic       a_s_ready, a_s_valid, a_s_last, a_m_ready, a_m_valid, a_m_last, a_full, a_empty;
    logic [7:0] a_s_data, a_m_data;
    logic [0:0] a_s_keep, a_m_keep;
    logic [2:0] a_level;

    logic       b_s_ready, b_s_valid, b_s_last, b_m_ready, b_m_valid, b_m_last, b_full, b_empty;
    logic [7:0] b_s_data, b_m_data;
    logic [0:0] b_s_keep, b_m_keep;
    logic [3:0] b_level;

    axis_fifo_buf #(.WIDTH(8), .DEPTH(4), .PACKET_MODE(1'b0)) u_a (
        .aclk(aclk), .aresetn(aresetn),
        .s_ready(a_s_ready), .s_valid(a_s_valid), .s_last(a_s_last), .s_data(a_s_data), .s_keep(a_s_keep),
        .m_ready(a_m_ready), .m_valid(a_m_valid), .m_last(a_m_last), .m_data(a_m_data), .m_keep(a_m_keep),
        .level(a_level), .full(a_full), .empty(a_empty)
    );

    axis_fifo_buf #(.WIDTH(8), .DEPTH(8), .PACKET_MODE(1'b1)) u_b (
        .aclk(aclk), .aresetn(aresetn),
        .s_ready(b_s_ready), .s_valid(b_s_valid), .s_last(b_s_last), .s_data(b_s_data), .s_keep(b_s_keep),
        .m_ready(b_m_ready), .m_valid(b_m_valid), .m_last(b_m_last), .m_data(b_m_data), .m_keep(b_m_keep),
        .level(b_level), .full(b_full), .empty(b_empty)
    );

    int         checks = 0;
    int         failures = 0;
    axis_beat_t qa[$];
    axis_beat_t qb[$];
    bit         rdy_en = 1'b0;

    function automatic axis_beat_t mk(input logic [7:0] d, input logic k, input logic l);
        axis_beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        return b;
    endfunction

    // One clock of stimulus on the selected instance (0 = A, 1 = B), with all
    // outputs compared against the model before the edge.
    task automatic step(input bit sel, input bit sv, input axis_beat_t beat, input bit mr,
                        output bit push, output bit pop);
        axis_beat_t cur[$];
        axis_beat_t exp_pl;
        int         depth, o_level;
        bit         any_last, exp_mv, exp_sr;
        logic       o_sr, o_mv, o_full, o_empty;
        logic [9:0] o_pl;
        if (sel) begin cur = qb; depth = 8; end
        else     begin cur = qa; depth = 4; end
        a_s_valid = !sel && sv;
        a_m_ready = !sel && mr;
        b_s_valid = sel && sv;
        b_m_ready = sel && mr;
        {a_s_data, a_s_keep, a_s_last} = beat;
        {b_s_data, b_s_keep, b_s_last} = beat;
        #1;
        if (sel) begin
            o_sr = b_s_ready; o_mv = b_m_valid; o_full = b_full; o_empty = b_empty;
            o_pl = {b_m_data, b_m_keep, b_m_last}; o_level = int'(b_level);
        end else begin
            o_sr = a_s_ready; o_mv = a_m_valid; o_full = a_full; o_empty = a_empty;
            o_pl = {a_m_data, a_m_keep, a_m_last}; o_level = int'(a_level);
        end
        any_last = 1'b0;
        foreach (cur[i]) if (cur[i].last) any_last = 1'b1;
        exp_mv = (cur.size() != 0) && (!sel || any_last || cur.size() == depth);
        exp_sr = rdy_en && (cur.size() < depth);
        exp_pl = '0;
        if (exp_mv) exp_pl = cur[0];

        checks += 6;
        if (o_sr !== exp_sr) begin
            failures++; $display("FAIL s_ready[%0d] got %b want %b", sel, o_sr, exp_sr);
        end
        if (o_mv !== exp_mv) begin
            failures++; $display("FAIL m_valid[%0d] got %b want %b", sel, o_mv, exp_mv);
        end
        if (o_level !== cur.size()) begin
            failures++; $display("FAIL level[%0d] got %0d want %0d", sel, o_level, cur.size());
        end
        if (o_full !== (cur.size() == depth)) begin
            failures++; $display("FAIL full[%0d] got %b want %b", sel, o_full, cur.size() == depth);
        end
        if (o_empty !== (cur.size() == 0)) begin
            failures++; $display("FAIL empty[%0d] got %b want %b", sel, o_empty, cur.size() == 0);
        end
        if (o_pl !== exp_pl) begin
            failures++; $display("FAIL payload[%0d] got %h want %h", sel, o_pl, exp_pl);
        end

        push = sv && exp_sr;
        pop  = mr && exp_mv;
        @(posedge aclk);
        rdy_en = 1'b1;
        if (pop) begin
            if (sel) void'(qb.pop_front());
            else     void'(qa.pop_front());
        end
        if (push) begin
            if (sel) qb.push_back(beat);
            else     qa.push_back(beat);
        end
        @(negedge aclk);
    endtask

    task automatic idle_inputs();
        a_s_valid = 1'b0; a_s_last = 1'b0; a_s_data = '0; a_s_keep = '0; a_m_ready = 1'b0;
        b_s_valid = 1'b0; b_s_last = 1'b0; b_s_data = '0; b_s_keep = '0; b_m_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge aclk);
        aresetn = 1'b0;
        idle_inputs();
        qa.delete();
        qb.delete();
        rdy_en = 1'b0;
        #1;
        checks += 2;
        if ({a_m_valid, a_s_ready, a_level, a_empty, a_full, a_m_data, a_m_keep, a_m_last} !== 18'b0_0_000_1_0_00000000_0_0) begin
            failures++;
            $display("FAIL reset_a got mv=%b sr=%b lvl=%0d e=%b f=%b d=%h", a_m_valid, a_s_ready, a_level, a_empty, a_full, a_m_data);
        end
        if ({b_m_valid, b_s_ready, b_level, b_empty, b_full, b_m_data, b_m_keep, b_m_last} !== 19'b0_0_0000_1_0_00000000_0_0) begin
            failures++;
            $display("FAIL reset_b got mv=%b sr=%b lvl=%0d e=%b f=%b d=%h", b_m_valid, b_s_ready, b_level, b_empty, b_full, b_m_data);
        end
        @(negedge aclk);
        aresetn = 1'b1;
    endtask

    task automatic test_reset();
        bit p, q;
        do_reset();
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b0, p, q);
        checks++;
        if (a_s_ready !== 1'b1) begin
            failures++; $display("FAIL ready_after_release got %b want 1", a_s_ready);
        end
    endtask

    task automatic test_fill_drain();
        bit p, q;
        do_reset();
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b0, p, q);
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, mk(8'(8'h11 * (i + 1)), 1'b1, i == 3), 1'b0, p, q);
        checks++;
        if (a_level !== 3'd4 || a_full !== 1'b1 || a_s_ready !== 1'b0) begin
            failures++; $display("FAIL fill got lvl=%0d f=%b sr=%b want 4 1 0", a_level, a_full, a_s_ready);
        end
        step(1'b0, 1'b1, mk(8'h55, 1'b1, 1'b0), 1'b0, p, q);
        checks++;
        if (a_level !== 3'd4) begin
            failures++; $display("FAIL fifth_beat got lvl=%0d want 4", a_level);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_m_data !== 8'(8'h11 * (i + 1))) begin
                failures++; $display("FAIL drain_order got %h want %h", a_m_data, 8'(8'h11 * (i + 1)));
            end
            step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b1, p, q);
        end
        checks++;
        if (a_empty !== 1'b1) begin
            failures++; $display("FAIL drained_empty got %b want 1", a_empty);
        end
    endtask

    task automatic test_single();
        bit p, q;
        step(1'b0, 1'b1, mk(8'hA5, 1'b1, 1'b1), 1'b1, p, q);
        checks++;
        if (a_m_valid !== 1'b1 || a_m_data !== 8'hA5) begin
            failures++; $display("FAIL single_latency got mv=%b d=%h want 1 a5", a_m_valid, a_m_data);
        end
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b1, p, q);
        checks++;
        if (a_level !== 3'd0 || a_m_valid !== 1'b0) begin
            failures++; $display("FAIL single_pop got lvl=%0d mv=%b want 0 0", a_level, a_m_valid);
        end
    endtask

    task automatic test_back_to_back();
        bit p, q;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, mk(8'(i), 1'b1, (i % 5) == 4), 1'b1, p, q);
            checks++;
            if (a_level !== 3'd1) begin
                failures++; $display("FAIL streaming_level beat %0d got %0d want 1", i, a_level);
            end
        end
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b1, p, q);
    endtask

    task automatic test_random();
        bit p, q;
        int pushed, popped, cyc;
        pushed = 0; popped = 0; cyc = 0;
        while (pushed < 1000 && cyc < 8000) begin
            step(1'b0, 1'($urandom), mk(8'($urandom), 1'($urandom), 1'($urandom)), 1'($urandom), p, q);
            pushed += int'(p);
            popped += int'(q);
            cyc++;
            checks++;
            if (int'(a_level) !== pushed - popped) begin
                failures++; $display("FAIL random_level got %0d want %0d", a_level, pushed - popped);
            end
        end
        checks++;
        if (pushed < 1000) begin
            failures++; $display("FAIL random_budget got %0d beats want 1000", pushed);
        end
        for (int i = 0; i < 20 && qa.size() != 0; i++) step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b1, p, q);
    endtask

    task automatic test_packet();
        bit p, q;
        int sent, cyc;
        do_reset();
        step(1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b0, p, q);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, mk(8'(8'h30 + i), 1'b1, 1'b0), 1'b1, p, q);
            checks++;
            if (b_m_valid !== 1'b0) begin
                failures++; $display("FAIL pkt_withheld beat %0d got %b want 0", i, b_m_valid);
            end
        end
        step(1'b1, 1'b1, mk(8'h33, 1'b1, 1'b1), 1'b1, p, q);
        checks++;
        if (b_m_valid !== 1'b1) begin
            failures++; $display("FAIL pkt_release got %b want 1", b_m_valid);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (b_m_last !== (k == 3) || b_m_data !== 8'(8'h30 + k)) begin
                failures++; $display("FAIL pkt_out beat %0d got l=%b d=%h", k, b_m_last, b_m_data);
            end
            step(1'b1, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b1, p, q);
        end
        checks++;
        if (b_empty !== 1'b1) begin
            failures++; $display("FAIL pkt_empty got %b want 1", b_empty);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 1'b1, mk(8'(8'h40 + i), 1'b1, 1'b0), 1'b0, p, q);
            checks++;
            if (b_m_valid !== (i == 7)) begin
                failures++; $display("FAIL long_pkt_gate beat %0d got %b want %b", i, b_m_valid, i == 7);
            end
        end
        checks++;
        if (b_level !== 4'd8) begin
            failures++; $display("FAIL long_pkt_full got %0d want 8", b_level);
        end
        sent = 8; cyc = 0;
        while ((qb.size() != 0 || sent < 10) && cyc < 200) begin
            step(1'b1, sent < 10, mk(8'(8'h40 + sent), 1'b1, sent == 9), 1'b1, p, q);
            sent += int'(p);
            cyc++;
        end
        checks++;
        if (b_empty !== 1'b1 || sent != 10) begin
            failures++; $display("FAIL long_pkt_deadlock got e=%b sent=%0d want 1 10", b_empty, sent);
        end
    endtask

    task automatic test_reset_mid();
        bit p, q;
        do_reset();
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b0, p, q);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, mk(8'(8'hC0 + i), 1'b1, 1'b0), 1'b0, p, q);
        checks++;
        if (a_level !== 3'd3) begin
            failures++; $display("FAIL mid_level got %0d want 3", a_level);
        end
        aresetn = 1'b0;
        idle_inputs();
        qa.delete();
        rdy_en = 1'b0;
        @(posedge aclk);
        #1;
        checks++;
        if (a_m_valid !== 1'b0 || a_level !== 3'd0 || a_empty !== 1'b1 || a_s_ready !== 1'b0 || a_m_data !== 8'h00) begin
            failures++;
            $display("FAIL mid_reset got mv=%b lvl=%0d e=%b sr=%b d=%h", a_m_valid, a_level, a_empty, a_s_ready, a_m_data);
        end
        @(negedge aclk);
        aresetn = 1'b1;
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b0, p, q);
        checks++;
        if (a_s_ready !== 1'b1) begin
            failures++; $display("FAIL mid_ready got %b want 1", a_s_ready);
        end
        step(1'b0, 1'b1, mk(8'h77, 1'b1, 1'b1), 1'b0, p, q);
        checks++;
        if (a_m_data !== 8'h77 || a_level !== 3'd1) begin
            failures++; $display("FAIL mid_fresh got d=%h lvl=%0d want 77 1", a_m_data, a_level);
        end
        step(1'b0, 1'b0, mk(8'h00, 1'b0, 1'b0), 1'b1, p, q);
    endtask

    // Neither instance may ever accept while full or present while empty.
    always @(posedge aclk) begin
        if (aresetn) begin
            if ((a_s_valid && a_s_ready && a_full) || (b_s_valid && b_s_ready && b_full)) begin
                failures++; $display("FAIL overflow a=%b b=%b", a_full, b_full);
            end
            if ((a_m_valid && a_empty) || (b_m_valid && b_empty)) begin
                failures++; $display("FAIL underflow a=%b b=%b", a_empty, b_empty);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        test_reset();
        test_fill_drain();
        test_single();
        test_back_to_back();
        test_random();
        test_packet();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
